ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter for the keyboard port, in the opposite direction to the scancode receive/decode path.
- Sends one command byte to the keyboard, e.g. 0xED (set LEDs) and its LED argument, then reports whether the device acknowledged the frame.
- Drives the open-drain PS/2 clock and data lines through pull-low enables; the top level owns the tristate buffers.
- `tx_active` lets the receive path ignore line activity while the host owns the bus.

---
 rtl/ps2_host_tx.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for the keyboard port.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop), then
// samples the device ACK and reports the outcome with a one-cycle done pulse.
// The PS/2 lines are open-drain; this block only produces pull-low enables.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   txdata[0:7]           byte to send (bit 0 = MSB, txdata[7] goes out first)
//   start                 single-cycle request, honoured only when idle
//   busy / tx_active      high while a transaction is in progress
//   done / error          end-of-transaction pulse; error = NACK or timeout
//   ps2_clk_in/_data_in   raw PS/2 lines
//   ps2_clk_low/_data_low 1 = pull the corresponding line low
//
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed attempt (NACK or timeout)
// is retried once with the same byte before done/error are reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] txdata,
  input  logic       start,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CNT = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_FRAME   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    n_q, n_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          nack_q, nack_d;
  logic          err_q, err_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  logic          fall, bus_idle, cnt_tmo;
  logic          attempt_end, attempt_fail, retrying;
  logic          frame_low;
  logic [2:0]    bidx;

  // Synchronisers reset to the idle (released) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall     = clk_prev_q & ~clk_sync_q;
  assign bus_idle = clk_sync_q & dat_sync_q;
  assign cnt_tmo  = (cnt_q == CW'(TIMEOUT_CYCLES));

  // An attempt ends on FRAME timeout, or in WAIT_IDLE on idle bus / timeout.
  // A fall in the timeout cycle wins over the timeout.
  assign attempt_end  = ((state_q == S_FRAME) && !fall && cnt_tmo) ||
                        ((state_q == S_WAIT) && (bus_idle || cnt_tmo));
  assign attempt_fail = ((state_q == S_WAIT) && bus_idle) ? nack_q : 1'b1;

`ifdef PS2_HOST_TX_RETRY_EN
  logic retry_q, retry_d;

  assign retrying = attempt_end & attempt_fail & ~retry_q;

  always_comb begin
    retry_d = retry_q;
    if (state_q == S_IDLE) begin
      retry_d = 1'b0;
    end else if (retrying) begin
      retry_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign retrying = 1'b0;
`endif

  // done is combinational in the last busy cycle, so a coincident start is
  // seen outside IDLE and ignored.
  assign done  = attempt_end & ~retrying;
  assign error = done ? attempt_fail : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    sh_d    = sh_q;
    par_d   = par_q;
    nack_d  = nack_q;
    err_d   = done ? attempt_fail : err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = txdata;
          par_d   = ~^txdata;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        if (cnt_q == CW'(REQ_CYCLES - 1)) begin
          cnt_d   = '0;
          n_d     = '0;
          state_d = S_FRAME;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FRAME: begin
        if (fall) begin
          cnt_d = '0;
          n_d   = n_q + 4'd1;
          if (n_q == 4'd10) begin
            nack_d  = dat_sync_q;
            state_d = S_WAIT;
          end
        end else if (!cnt_tmo) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (!attempt_end) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (attempt_end) begin
      cnt_d   = '0;
      state_d = retrying ? S_INHIBIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
    end
  end

  // Data line during FRAME: start bit until the first fall, then bits, parity,
  // and released from edge 10 on.
  assign bidx = 3'(n_q - 4'd1);

  always_comb begin
    frame_low = 1'b0;
    if (n_q == 4'd0) begin
      frame_low = 1'b1;
    end else if (n_q <= 4'd8) begin
      frame_low = ~sh_q[bidx];
    end else if (n_q == 4'd9) begin
      frame_low = ~par_q;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign tx_active    = busy;
  assign ps2_clk_low  = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_data_low = (state_q == S_REQ) ||
                        ((state_q == S_FRAME) && frame_low && !attempt_end);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int REQ  = 4;
  localparam int TMO  = 200;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 2;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] txdata;
  logic       start;
  logic       busy, tx_active, done, error;
  logic       ps2_clk_low, ps2_data_low;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low, dev_data_low;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   win_s = -1000;
  int   done_cnt = 0;
  logic last_err = 1'b0;
  logic prev_done = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .txdata      (txdata),
    .start       (start),
    .busy        (busy),
    .tx_active   (tx_active),
    .done        (done),
    .error       (error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_low (ps2_clk_low),
    .ps2_data_low(ps2_data_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the device must see it: bits 1..8 LSB first, odd parity, stop=1.
  function automatic logic [10:1] exp_bits(input logic [7:0] b);
    logic [10:1] r;
    for (int i = 1; i <= 8; i++) r[i] = b[i-1];
    r[9]  = ~^b;
    r[10] = 1'b1;
    return r;
  endfunction

  // Per-cycle checks against the timing model.
  always @(negedge clk) begin
    int k;
    if (reset) begin
      last_err  = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("tx_active_eq_busy", tx_active, busy);
      if (!busy) begin
        chk("idle_clk_low", ps2_clk_low, 0);
        chk("idle_data_low", ps2_data_low, 0);
      end
      k = cyc - win_s;
      if (win_s >= 0 && k >= 1 && k <= INH + REQ) begin
        chk("win_clk_low", ps2_clk_low, 1);
        chk("win_data_low", ps2_data_low, (k > INH) ? 1 : 0);
        chk("win_busy", busy, 1);
      end
      if (win_s >= 0 && k == 0) chk("start_cycle_busy", busy, 0);
      if (done) begin
        chk("done_single", prev_done, 0);
        done_cnt++;
        last_err = error;
      end else begin
        chk("error_hold", error, last_err);
      end
      prev_done = done;
    end
  end

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    txdata = b;
    start  = 1'b1;
    win_s  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output logic err,
                           output int at, output logic cl, output logic dl);
    got = 1'b0; err = 1'bx; at = -1; cl = 1'bx; dl = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1; err = error; at = cyc; cl = ps2_clk_low; dl = ps2_data_low;
        return;
      end
    end
  endtask

  // Device model: 20 cycles low / 20 high per bit, samples at the end of low.
  task automatic dev_frame(input bit ack, input int start_at, input int reset_at,
                           output logic [10:1] samp, output bit ok);
    int w;
    samp = '0;
    ok   = 1'b0;
    w    = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) return;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == reset_at) begin
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_clk_low", ps2_clk_low, 0);
        chk("rst_data_low", ps2_data_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        win_s = -1000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        return;
      end
      for (int j = 0; j < HALF; j++) begin
        @(negedge clk);
        if (i == start_at && j == 2) begin
          txdata = 8'h00;
          start  = 1'b1;
        end
        if (i == start_at && j == 3) start = 1'b0;
      end
      if (i <= 10) samp[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == 11) dev_data_low = 1'b0;
      if (i < 11) repeat (HALF) @(negedge clk);
    end
    ok = 1'b1;
  endtask

  task automatic txn(input logic [7:0] b, input bit ack, input int start_at,
                     output logic [10:1] samp);
    bit   ok, got;
    logic err, cl, dl;
    int   at, dc0, nfr;
    nfr = ack ? 1 : FAIL_ATTEMPTS;
    dc0 = done_cnt;
    do_start(b);
    for (int f = 0; f < nfr; f++) begin
      dev_frame(ack, (f == 0) ? start_at : 0, 0, samp, ok);
      chk("req_seen", ok, 1);
      chk("frame_bits", samp, exp_bits(b));
    end
    wait_done(100, got, err, at, cl, dl);
    chk("done_seen", got, 1);
    chk("done_error", err, ack ? 0 : 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    repeat ((start_at != 0) ? 300 : 5) @(negedge clk);
    chk("done_count", done_cnt - dc0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:1] s;
    logic [7:0]  b;
    bit          got, ack;
    logic        err, cl, dl;
    int          at, s0, dc0;

    reset = 1'b1; start = 1'b0; txdata = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_tx_active", tx_active, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_clk_low", ps2_clk_low, 0);
    chk("reset_data_low", ps2_data_low, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    txn(8'hED, 1'b1, 0, s);
    chk("ed_literal_bits", s, 10'b11_1110_1101);
    txn(8'h01, 1'b1, 0, s);
    chk("parity_01", s[9], 0);
    txn(8'hFF, 1'b1, 0, s);
    chk("parity_ff", s[9], 1);
    txn(8'h00, 1'b0, 0, s);

    // Device never clocks: done with error after TMO cycles from clock release.
    dc0 = done_cnt;
    do_start(8'h5A);
    s0 = win_s;
    wait_done(3 * TMO + 100, got, err, at, cl, dl);
    chk("tmo_done_seen", got, 1);
    chk("tmo_done_cycle", at, s0 + (INH + REQ + 1 + TMO) * FAIL_ATTEMPTS);
    chk("tmo_error", err, 1);
    chk("tmo_clk_released", cl, 0);
    chk("tmo_data_released", dl, 0);
    repeat (5) @(negedge clk);
    chk("tmo_done_count", done_cnt - dc0, 1);

    // Reset in the middle of a frame, then a clean frame.
    dc0 = done_cnt;
    do_start(8'hA5);
    dev_frame(1'b1, 0, 5, s, got);
    chk("rst_req_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("rst_busy_after", busy, 0);
    chk("rst_no_done", done_cnt - dc0, 0);
    txn(8'h3C, 1'b1, 0, s);

    // start during a frame is ignored.
    txn(8'hED, 1'b1, 3, s);

    for (int r = 0; r < 6; r++) begin
      b   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      txn(b, ack, 0, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
